// File: rtl/sra_iterative.sv
// Iterative right shifter (logical / arithmetic), one binary-weighted stage per clock.
// Latency: result pulse SHAMT_W+1 edges after the accepting edge; data-independent.
// Backpressure: none queued; ctrl_start is ignored while busy, accepted again from DONE.
module sra_iterative #(
    parameter int WIDTH   = 32,
    // Must equal log2(WIDTH); the number of shift stages equals SHAMT_W.
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic               ctrl_arith,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index of the amount bit handled by the first stage (the MSB of the amount).
    localparam logic [SHAMT_W-1:0] LAST_IDX = SHAMT_W[SHAMT_W-1:0] - 1'b1;
    localparam logic [SHAMT_W-1:0] ONE_AMT  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONES     = '1;

    state_t             state;
    state_t             state_nxt;

    // Captured request: working value, shift amount and the fill bit.
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] amt;
    logic               fill;

    // Stage counter: 0 on the first shift edge, LAST_IDX on the final one.
    logic [SHAMT_W-1:0] stage;

    logic               accept;
    logic               last_stage;
    logic [SHAMT_W-1:0] bit_idx;
    logic [SHAMT_W-1:0] sh_dist;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   stage_out;

    // State register; synchronous reset aborts any request in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_stage = (state == SHIFT) && (stage == LAST_IDX);

    // Next-state and handshake outputs; busy/RDY decode directly from state.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_stage) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                data_resultRDY = 1'b1;
                // A start here is taken exactly as from IDLE, so back-to-back
                // requests cost SHAMT_W+1 cycles each.
                if (ctrl_start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One stage of the shifter: the stage handles amount bit (SHAMT_W-1-stage),
    // whose weight is 2^(SHAMT_W-1-stage). Vacated MSBs take the captured fill bit.
    always_comb begin
        bit_idx   = LAST_IDX - stage;
        sh_dist   = ONE_AMT << bit_idx;
        fill_mask = fill ? ~(ONES >> sh_dist) : '0;
        stage_out = work;
        if (amt[bit_idx]) begin
            stage_out = (work >> sh_dist) | fill_mask;
        end
    end

    // Datapath: capture on accept, shift once per SHIFT edge, publish on the last stage.
    // data_result is only written here, so it holds steady through DONE and IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            work        <= '0;
            amt         <= '0;
            fill        <= 1'b0;
            stage       <= '0;
            data_result <= '0;
        end else if (accept) begin
            work  <= data_operandA;
            amt   <= ctrl_shiftamt;
            // Sign comes from the operand as captured, not from later input values.
            fill  <= ctrl_arith & data_operandA[WIDTH-1];
            stage <= '0;
        end else if (state == SHIFT) begin
            work  <= stage_out;
            stage <= stage + ONE_AMT;
            if (last_stage) begin
                data_result <= stage_out;
            end
        end
    end

endmodule
